spi_master: RTL and testbench

- Clocked SPI master that drives the team's SPI slave + single-port RAM subsystem.
- Takes one-shot commands from a host-side valid/ready interface and serialises each as a framed MOSI transfer under SS_n.
- For read-data commands, captures the 8-bit MISO reply and returns it with a one-cycle strobe.
- Shares the slave's system clock: one bit per clk, no separate SCLK.

---
 rtl/spi_pkg.sv | 20 ++
 rtl/spi_shift_reg.sv | 24 ++
 rtl/spi_master.sv | 131 +++++++++++++
 tb/tb_spi_master.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// rtl/spi_pkg.sv - shared command encodings, frame sizes and master state type
package spi_pkg;

  localparam logic [1:0] CMD_WR_ADDR = 2'b00;
  localparam logic [1:0] CMD_WR_DATA = 2'b01;
  localparam logic [1:0] CMD_RD_ADDR = 2'b10;
  localparam logic [1:0] CMD_RD_DATA = 2'b11;

  localparam int DATA_W     = 8;
  localparam int FRAME_BITS = 11;

  typedef enum logic [2:0] {
    IDLE,
    SEND,
    GAP,
    CAPTURE,
    END
  } state_t;

endpackage

// File: rtl/spi_shift_reg.sv
// rtl/spi_shift_reg.sv - parallel-load / serial-in shift register, MSB shifts out first
module spi_shift_reg #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_data,
  input  logic         shift_en,
  input  logic         serial_in,
  output logic [W-1:0] q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else if (load) begin
      q <= load_data;
    end else if (shift_en) begin
      q <= {q[W-2:0], serial_in};
    end
  end

endmodule

// File: rtl/spi_master.sv
// rtl/spi_master.sv - command-driven SPI master, one bit per clk, framed under SS_n
module spi_master #(
  parameter int DATA_W = 8,
  parameter int RD_GAP = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_type,
  input  logic [DATA_W-1:0] cmd_data,
  output logic              rd_valid,
  output logic [DATA_W-1:0] rd_data,
  output logic              busy,
  output logic              SS_n,
  output logic              MOSI,
  input  logic              MISO
);

  import spi_pkg::*;

  localparam int         FRAME_W   = DATA_W + 3;
  localparam logic [3:0] SEND_LAST = 4'(FRAME_W - 1);
  localparam logic [3:0] GAP_LAST  = 4'(RD_GAP - 1);
  localparam logic [3:0] CAP_LAST  = 4'(DATA_W - 1);

  state_t              state;
  logic [3:0]          cnt;
  logic                is_rd;
  logic                accept;
  logic [DATA_W-1:0]   payload;
  logic [FRAME_W-1:0]  frame;
  logic [FRAME_W-1:0]  tx_q;
  logic [DATA_W-1:0]   rx_q;
  logic                unused_bits;

  assign accept    = (state == IDLE) && cmd_valid;
  assign payload   = (cmd_type == CMD_RD_DATA) ? '0 : cmd_data;
  assign frame     = {cmd_type[1], cmd_type, payload};
  assign cmd_ready = (state == IDLE);
  assign busy      = (state != IDLE);

  // TX shifts in zeros, so its MSB is already 0 once the frame has gone out
  assign MOSI = tx_q[FRAME_W-1];

  spi_shift_reg #(.W(FRAME_W)) u_tx (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (accept),
    .load_data (frame),
    .shift_en  (state == SEND),
    .serial_in (1'b0),
    .q         (tx_q)
  );

  // RX only moves in CAPTURE so MISO is never looked at elsewhere
  spi_shift_reg #(.W(DATA_W)) u_rx (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (accept),
    .load_data ('0),
    .shift_en  (state == CAPTURE),
    .serial_in (MISO),
    .q         (rx_q)
  );

  assign unused_bits = ^{tx_q[FRAME_W-2:0], rx_q[DATA_W-1]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      cnt      <= '0;
      is_rd    <= 1'b0;
      SS_n     <= 1'b1;
      rd_valid <= 1'b0;
      rd_data  <= '0;
    end else begin
      rd_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (cmd_valid) begin
            state <= SEND;
            cnt   <= '0;
            is_rd <= (cmd_type == CMD_RD_DATA);
            SS_n  <= 1'b0;
          end
        end
        SEND: begin
          if (cnt == SEND_LAST) begin
            cnt <= '0;
            if (is_rd) begin
              state <= GAP;
            end else begin
              state <= END;
              SS_n  <= 1'b1;
            end
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
        GAP: begin
          if (cnt == GAP_LAST) begin
            cnt   <= '0;
            state <= CAPTURE;
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
        CAPTURE: begin
          if (cnt == CAP_LAST) begin
            cnt      <= '0;
            state    <= END;
            SS_n     <= 1'b1;
            rd_valid <= 1'b1;
            rd_data  <= {rx_q[DATA_W-2:0], MISO};
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
        END: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
          SS_n  <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spi_master.sv
// tb/tb_spi_master.sv - randomized bench with a frame-level model of master and slave RAM
module tb_spi_master;
  import spi_pkg::*;

  localparam int RD_GAP = 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       cmd_valid = 1'b0;
  logic [1:0] cmd_type = 2'b00;
  logic [7:0] cmd_data = 8'h00;
  logic       cmd_ready, rd_valid, busy, SS_n, MOSI;
  logic       MISO;
  logic [7:0] rd_data;

  always #5 clk = ~clk;

  spi_master #(.DATA_W(8), .RD_GAP(RD_GAP)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_type  (cmd_type),
    .cmd_data  (cmd_data),
    .rd_valid  (rd_valid),
    .rd_data   (rd_data),
    .busy      (busy),
    .SS_n      (SS_n),
    .MOSI      (MOSI),
    .MISO      (MISO)
  );

  int total = 0;
  int bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Frame-level model: one active frame, offsets counted from the accept edge
  int         cyc = 0;
  int         last_acc = -1000;
  bit         f_act = 1'b0;
  int         f_k = 0;
  logic [1:0] f_t = 2'b00;
  logic [7:0] f_d = 8'h00;
  logic [7:0] f_reply = 8'h00;
  logic [7:0] m_addr = 8'h00;
  logic [7:0] m_ram [256];
  logic [7:0] m_rd = 8'h00;
  int         m_off;

  function automatic int end_of(input logic [1:0] t);
    return (t == CMD_RD_DATA) ? 20 + RD_GAP : 12;
  endfunction

  always @(posedge clk) begin
    cyc++;
    if (!rst_n) begin
      f_act = 1'b0;
      m_rd  = 8'h00;
    end else if (!f_act && cmd_valid) begin
      f_act    = 1'b1;
      f_k      = cyc;
      f_t      = cmd_type;
      f_d      = (cmd_type == CMD_RD_DATA) ? 8'h00 : cmd_data;
      f_reply  = m_ram[m_addr];
      last_acc = cyc;
    end else if (f_act) begin
      m_off = cyc - f_k + 1;
      if (m_off == end_of(f_t)) begin
        case (f_t)
          CMD_WR_ADDR, CMD_RD_ADDR: m_addr = f_d;
          CMD_WR_DATA:              m_ram[m_addr] = f_d;
          default:                  m_rd = f_reply;
        endcase
      end else if (m_off > end_of(f_t)) begin
        f_act = 1'b0;
      end
    end
  end

  int   d_off;
  always @(negedge clk) begin
    MISO = 1'bx;
    if (rst_n && f_act && f_t == CMD_RD_DATA) begin
      d_off = cyc - f_k + 1 - 12 - RD_GAP;
      if (d_off >= 0 && d_off <= 7) MISO = f_reply[7 - d_off];
    end
  end

  int          c_off;
  logic [10:0] c_fr;
  logic        e_ss, e_mosi, e_busy, e_rdy, e_rdv;
  logic [7:0]  e_rd;
  always @(negedge clk) begin
    e_ss = 1'b1; e_mosi = 1'b0; e_busy = 1'b0; e_rdy = 1'b1; e_rdv = 1'b0; e_rd = m_rd;
    if (!rst_n) begin
      e_rd = 8'h00;
    end else if (f_act) begin
      c_off  = cyc - f_k + 1;
      c_fr   = {f_t[1], f_t, f_d};
      e_busy = 1'b1;
      e_rdy  = 1'b0;
      if (c_off <= 11) begin
        e_ss   = 1'b0;
        e_mosi = c_fr[11 - c_off];
      end else if (c_off < end_of(f_t)) begin
        e_ss = 1'b0;
      end else begin
        e_rdv = (f_t == CMD_RD_DATA);
      end
    end
    check($sformatf("ss_n@%0d", cyc), SS_n, e_ss);
    check($sformatf("mosi@%0d", cyc), MOSI, e_mosi);
    check($sformatf("busy@%0d", cyc), busy, e_busy);
    check($sformatf("cmd_ready@%0d", cyc), cmd_ready, e_rdy);
    check($sformatf("rd_valid@%0d", cyc), rd_valid, e_rdv);
    check($sformatf("rd_data@%0d", cyc), rd_data, e_rd);
  end

  task automatic run_cmd(input logic [1:0] t, input logic [7:0] d, input int gap,
                         output int k, output logic [10:0] seq, output int rdv_off,
                         output int rdv_n, output logic [7:0] rdv_d,
                         output logic ss12, output logic rdy_after);
    int  off;
    int  eo;
    bit  acc;
    bit  done;
    acc = 1'b0; done = 1'b0; k = 0; seq = '0; rdv_off = -1; rdv_n = 0;
    rdv_d = 8'h00; ss12 = 1'b0; rdy_after = 1'b0;
    eo = end_of(t);
    repeat (gap) @(negedge clk);
    @(negedge clk);
    cmd_valid = 1'b1; cmd_type = t; cmd_data = d;
    for (int g = 0; g < 60 && !done; g++) begin
      @(negedge clk);
      if (!acc && last_acc == cyc) begin
        acc = 1'b1; k = cyc; cmd_valid = 1'b0;
        cmd_type = 2'($urandom); cmd_data = 8'($urandom);
      end
      if (acc) begin
        off = cyc - k + 1;
        if (off >= 1 && off <= 11) seq[11 - off] = MOSI;
        if (rd_valid) begin rdv_n++; rdv_off = off; rdv_d = rd_data; end
        if (off == 12) ss12 = SS_n;
        if (off == eo + 1) begin rdy_after = cmd_ready; done = 1'b1; end
      end
    end
    if (!done) begin
      total++; bad++;
      $display("FAIL cmd_timeout: got accepted=%0d want frame complete", acc);
      cmd_valid = 1'b0;
    end
  endtask

  int          k, k1, k2, rdv_off, rdv_n, n_fall, ss_hi;
  logic [10:0] seq;
  logic [7:0]  rdv_d;
  logic        ss12, rdy_after, prev_ss;

  initial begin
    for (int i = 0; i < 256; i++) m_ram[i] = 8'($urandom);

    #1 rst_n = 1'b0;
    #3;
    check("rst_ss_n", SS_n, 1'b1);
    check("rst_mosi", MOSI, 1'b0);
    check("rst_cmd_ready", cmd_ready, 1'b1);
    check("rst_rd_valid", rd_valid, 1'b0);
    check("rst_rd_data", rd_data, 8'h00);
    repeat (3) @(negedge clk);
    #1 rst_n = 1'b1;

    run_cmd(CMD_WR_ADDR, 8'hA5, 1, k, seq, rdv_off, rdv_n, rdv_d, ss12, rdy_after);
    check("wr_addr_a5_bits", seq, 11'b00010100101);
    check("wr_addr_ss_n_k12", ss12, 1'b1);
    check("wr_addr_ready_k13", rdy_after, 1'b1);
    check("wr_addr_no_rd_valid", rdv_n, 0);

    run_cmd(CMD_WR_ADDR, 8'h05, 0, k, seq, rdv_off, rdv_n, rdv_d, ss12, rdy_after);
    run_cmd(CMD_WR_DATA, 8'h3C, 0, k, seq, rdv_off, rdv_n, rdv_d, ss12, rdy_after);
    check("wr_data_3c_bits", seq, 11'b00100111100);
    run_cmd(CMD_RD_DATA, 8'hEE, 2, k, seq, rdv_off, rdv_n, rdv_d, ss12, rdy_after);
    check("rd_data_bits", seq, 11'b11100000000);
    check("rd_valid_offset", rdv_off, 20 + RD_GAP);
    check("rd_valid_pulses", rdv_n, 1);
    check("rd_data_3c", rdv_d, 8'h3C);
    check("rd_ready_after", rdy_after, 1'b1);

    // back-to-back with cmd_valid held high across both frames
    k1 = -1; k2 = -1; n_fall = 0; ss_hi = 0; prev_ss = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_type = CMD_WR_ADDR; cmd_data = 8'h10;
    for (int i = 0; i < 45; i++) begin
      @(negedge clk);
      if (k1 < 0 && last_acc == cyc) begin
        k1 = cyc; cmd_type = CMD_WR_DATA; cmd_data = 8'h77;
      end else if (k1 >= 0 && k2 < 0 && last_acc == cyc) begin
        k2 = cyc; cmd_valid = 1'b0;
      end
      if (prev_ss && !SS_n) n_fall++;
      if (k1 >= 0 && k2 < 0 && SS_n) ss_hi++;
      prev_ss = SS_n;
    end
    cmd_valid = 1'b0;
    check("b2b_accept_spacing", k2 - k1, 13);
    check("b2b_ss_high_gap", ss_hi, 2);
    check("b2b_ss_fall_count", n_fall, 2);

    run_cmd(CMD_WR_ADDR, 8'h20, 0, k, seq, rdv_off, rdv_n, rdv_d, ss12, rdy_after);
    run_cmd(CMD_WR_DATA, 8'hC3, 0, k, seq, rdv_off, rdv_n, rdv_d, ss12, rdy_after);
    run_cmd(CMD_RD_ADDR, 8'h20, 0, k, seq, rdv_off, rdv_n, rdv_d, ss12, rdy_after);
    check("rd_addr_20_bits", seq, 11'b11000100000);
    run_cmd(CMD_RD_DATA, 8'h00, 0, k, seq, rdv_off, rdv_n, rdv_d, ss12, rdy_after);
    check("loop_20_data", rdv_d, 8'hC3);
    check("loop_20_pulses", rdv_n, 1);

    run_cmd(CMD_WR_ADDR, 8'hFF, 0, k, seq, rdv_off, rdv_n, rdv_d, ss12, rdy_after);
    run_cmd(CMD_WR_DATA, 8'h00, 0, k, seq, rdv_off, rdv_n, rdv_d, ss12, rdy_after);
    run_cmd(CMD_RD_ADDR, 8'hFF, 0, k, seq, rdv_off, rdv_n, rdv_d, ss12, rdy_after);
    run_cmd(CMD_RD_DATA, 8'h5A, 0, k, seq, rdv_off, rdv_n, rdv_d, ss12, rdy_after);
    check("loop_ff_data", rdv_d, 8'h00);
    check("loop_ff_pulses", rdv_n, 1);

    run_cmd(CMD_WR_ADDR, 8'h20, 0, k, seq, rdv_off, rdv_n, rdv_d, ss12, rdy_after);
    run_cmd(CMD_RD_DATA, 8'h00, 0, k, seq, rdv_off, rdv_n, rdv_d, ss12, rdy_after);
    check("reread_20_data", rdv_d, 8'hC3);
    run_cmd(CMD_RD_ADDR, 8'h33, 0, k, seq, rdv_off, rdv_n, rdv_d, ss12, rdy_after);
    check("rd_addr_no_rd_valid", rdv_n, 0);
    check("rd_addr_keeps_rd_data", rd_data, 8'hC3);

    // abandon a read-data frame during SEND bit 5
    @(negedge clk);
    cmd_valid = 1'b1; cmd_type = CMD_RD_DATA; cmd_data = 8'h00;
    k = -1;
    for (int i = 0; i < 20 && (k < 0 || cyc - k + 1 < 6); i++) begin
      @(negedge clk);
      if (k < 0 && last_acc == cyc) begin k = cyc; cmd_valid = 1'b0; end
    end
    check("midframe_reached_bit5", cyc - k + 1, 6);
    #1 rst_n = 1'b0;
    #1;
    check("midframe_ss_n_async", SS_n, 1'b1);
    check("midframe_busy_async", busy, 1'b0);
    check("midframe_rd_data_async", rd_data, 8'h00);
    @(posedge clk);
    @(negedge clk);
    #1 rst_n = 1'b1;
    rdv_n = 0;
    repeat (30) begin
      @(negedge clk);
      if (rd_valid) rdv_n++;
    end
    check("midframe_no_rd_valid", rdv_n, 0);
    check("midframe_rd_data_clear", rd_data, 8'h00);

    for (int i = 0; i < 150; i++) begin
      run_cmd(2'($urandom_range(0, 3)), 8'($urandom), $urandom_range(0, 3),
              k, seq, rdv_off, rdv_n, rdv_d, ss12, rdy_after);
    end

    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
